mem_stage: RTL

Memory-access pipeline stage of the five-stage CPU. It sits between the execute stage and the writeback stage: it accepts instructions over the EXE→MEM valid/allowin handshake and waits for the data-SRAM response of any load or store issued by EXE. It extracts and extends load data, then drives the MEM→WB bus that the writeback stage consumes. It also exports its destination register to decode for hazard detection.

---
 rtl/mem_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the five-stage CPU pipeline. It takes instructions
// from EXE, waits for the data-SRAM response of any load or store that EXE
// already issued, extracts and extends load data, and hands the completed
// instruction to WB. It also reports its destination register to decode
// for hazard detection.
//
// Handshake (both sides): a transfer happens on a rising edge where the
// producer's valid and the consumer's allowin are both high. A producer
// holds valid and payload stable until the transfer happens. allowin may
// depend combinationally on the downstream allowin.
//
// Ports:
//   clk               in   1    rising-edge clock
//   resetn            in   1    asynchronous active-low reset
//   exe_to_mem_valid  in   1    EXE holds a valid instruction
//   exe_to_mem_bus    in   75   {mem_we,res_from_mem,load_type[2:0],gr_we,
//                                dest[4:0],alu_result[31:0],pc[31:0]}
//   mem_allowin       out  1    MEM can accept an instruction this cycle
//   data_sram_data_ok in   1    response for the single outstanding request
//   data_sram_rdata   in   32   read data, valid with data_ok
//   wb_allowin        in   1    WB can accept
//   mem_to_wb_valid   out  1    MEM presents a completed instruction
//   mem_to_wb_bus     out  70   {gr_we,dest[4:0],final_result[31:0],pc[31:0]}
//   gr_we_mem         out  1    gr_we of the valid MEM instruction, else 0
//   dest_mem          out  5    dest of the valid MEM instruction, else 0
//   mem_load_pending  out  1    valid load still waiting for its response
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int EXE_TO_MEM_BUS_WD = 75,
    parameter int MEM_TO_WB_BUS_WD  = 70
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         exe_to_mem_valid,
    input  logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus,
    output logic                         mem_allowin,
    input  logic                         data_sram_data_ok,
    input  logic [31:0]                  data_sram_rdata,
    input  logic                         wb_allowin,
    output logic                         mem_to_wb_valid,
    output logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus,
    output logic                         gr_we_mem,
    output logic [4:0]                   dest_mem,
    output logic                         mem_load_pending
);

    // Load type encodings carried on the EXE->MEM bus.
    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    // Stage state.
    logic                         r_mem_valid;
    logic [EXE_TO_MEM_BUS_WD-1:0] r_bus;
    logic                         r_ok_buf;
    logic [31:0]                  r_rdata_buf;

    // Decoded fields of the held instruction.
    logic        w_mem_we;
    logic        w_res_from_mem;
    logic [2:0]  w_load_type;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;

    assign w_mem_we       = r_bus[74];
    assign w_res_from_mem = r_bus[73];
    assign w_load_type    = r_bus[72:70];
    assign w_gr_we        = r_bus[69];
    assign w_dest         = r_bus[68:64];
    assign w_alu_result   = r_bus[63:32];
    assign w_pc           = r_bus[31:0];

    // Handshake logic.
    logic w_need_ok;
    logic w_ready_go;
    logic w_leave;

    assign w_need_ok   = w_mem_we | w_res_from_mem;
    assign w_ready_go  = !w_need_ok | data_sram_data_ok | r_ok_buf;
    assign mem_allowin = !r_mem_valid | (w_ready_go & wb_allowin);
    assign mem_to_wb_valid = r_mem_valid & w_ready_go;
    assign w_leave     = mem_to_wb_valid & wb_allowin;

    // Instruction register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_valid <= 1'b0;
            r_bus       <= '0;
        end else begin
            if (mem_allowin) begin
                r_mem_valid <= exe_to_mem_valid;
            end
            if (exe_to_mem_valid && mem_allowin) begin
                r_bus <= exe_to_mem_bus;
            end
        end
    end

    // Response buffer: a response that arrives while WB stalls must be kept,
    // because data_ok is a one-cycle pulse and will not be repeated.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ok_buf    <= 1'b0;
            r_rdata_buf <= '0;
        end else if (w_leave) begin
            r_ok_buf <= 1'b0;
        end else if (r_mem_valid && data_sram_data_ok && !r_ok_buf && !wb_allowin) begin
            r_ok_buf    <= 1'b1;
            r_rdata_buf <= data_sram_rdata;
        end
    end

    // Load data extraction. Misaligned addresses are not trapped here.
    logic [31:0] w_ld;
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_ld  = r_ok_buf ? r_rdata_buf : data_sram_rdata;
    assign w_off = w_alu_result[1:0];

    always_comb begin
        w_byte = w_ld[7:0];
        case (w_off)
            2'd1:    w_byte = w_ld[15:8];
            2'd2:    w_byte = w_ld[23:16];
            2'd3:    w_byte = w_ld[31:24];
            default: w_byte = w_ld[7:0];
        endcase
        w_half = w_off[1] ? w_ld[31:16] : w_ld[15:0];
    end

    always_comb begin
        w_load_data = w_ld;
        case (w_load_type)
            LT_LW:   w_load_data = w_ld;
            LT_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            LT_LBU:  w_load_data = {24'd0, w_byte};
            LT_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            LT_LHU:  w_load_data = {16'd0, w_half};
            default: w_load_data = w_ld;   // unused codes behave as lw
        endcase
    end

    logic [31:0] w_final_result;
    assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;

    assign mem_to_wb_bus = {w_gr_we, w_dest, w_final_result, w_pc};

    // Hazard info for decode.
    assign gr_we_mem = r_mem_valid & w_gr_we;
    assign dest_mem  = r_mem_valid ? w_dest : 5'd0;

    assign mem_load_pending = r_mem_valid & w_res_from_mem & !r_ok_buf & !data_sram_data_ok;

endmodule
